// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for a simple bus-based datapath. It generates every
// per-cycle strobe the datapath needs. Each instruction runs a three-step
// fetch (T0-T2) followed by decode/execute (T3-T5). The execute steps cover
// three-register ALU instructions, nop and halt.
//
// The unit waits on the memory read handshake in T1. It stops in HALT on a
// halt opcode, on a stop request at an instruction boundary, or when memory
// fails to answer within MEM_TIMEOUT cycles.
//
// Ports
//   i_clock          system clock, rising edge
//   i_clr            asynchronous reset, active-low
//   i_ir[31:0]       datapath IR contents, valid from T3 of the current instruction
//   i_mem_ready      memory read data is valid on the datapath this cycle
//   i_stop           level request: halt at the next instruction boundary
//   o_pcout, o_zlowout, o_mdrout            bus drive enables
//   o_pcin, o_irin, o_yin, o_zin,
//   o_marin, o_mdrin                        register load enables
//   o_incpc          ALU PC+1 request (asserted with o_zin in T0)
//   o_read           memory read strobe
//   o_rin[NUM_REGS]  one-hot register-file load enable
//   o_rout[NUM_REGS] one-hot register-file bus drive enable
//   o_alu_select[5]  ALU operation code
//   o_run            1 while sequencing, 0 in HALT
//   o_illegal        sticky: an undefined opcode was decoded
//   o_mem_err        sticky: memory read timed out
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int OP_W        = 5,
    parameter int RSEL_W      = 4,
    parameter int NUM_REGS    = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                i_clock,
    input  logic                i_clr,
    input  logic [31:0]         i_ir,
    input  logic                i_mem_ready,
    input  logic                i_stop,
    output logic                o_pcout,
    output logic                o_zlowout,
    output logic                o_mdrout,
    output logic                o_pcin,
    output logic                o_irin,
    output logic                o_yin,
    output logic                o_zin,
    output logic                o_marin,
    output logic                o_mdrin,
    output logic                o_incpc,
    output logic                o_read,
    output logic [NUM_REGS-1:0] o_rin,
    output logic [NUM_REGS-1:0] o_rout,
    output logic [4:0]          o_alu_select,
    output logic                o_run,
    output logic                o_illegal,
    output logic                o_mem_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    // IR field positions: opcode at the top, then Ra, Rb, Rc packed below it.
    localparam int OP_LO = 32 - OP_W;
    localparam int RA_LO = OP_LO - RSEL_W;
    localparam int RB_LO = RA_LO - RSEL_W;
    localparam int RC_LO = RB_LO - RSEL_W;

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b00000);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(5'b00101);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'(5'b00110);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b01001);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b01010);
    localparam logic [OP_W-1:0] OP_NEG  = OP_W'(5'b10000);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5'b10001);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

    localparam logic [NUM_REGS-1:0] ONE_HOT_R0 = NUM_REGS'(1);

    typedef enum logic [2:0] {
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    state_t           r_state;
    logic             r_live;      // 0 only in the first cycle after reset release
    logic [CNT_W-1:0] r_wait_cnt;  // T1 cycles spent without mem_ready
    logic             r_illegal;
    logic             r_mem_err;

    // Instruction field decode
    logic [OP_W-1:0]     w_op;
    logic [RSEL_W-1:0]   w_ra;
    logic [RSEL_W-1:0]   w_rb;
    logic [RSEL_W-1:0]   w_rc;
    logic [NUM_REGS-1:0] w_ra_oh;
    logic [NUM_REGS-1:0] w_rb_oh;
    logic [NUM_REGS-1:0] w_rc_oh;
    logic                w_is_alu;
    logic                w_unary;
    logic [4:0]          w_alu_sel;
    logic                w_unused_ir;

    assign w_op    = i_ir[31:OP_LO];
    assign w_ra    = i_ir[OP_LO-1:RA_LO];
    assign w_rb    = i_ir[RA_LO-1:RB_LO];
    assign w_rc    = i_ir[RB_LO-1:RC_LO];
    assign w_ra_oh = ONE_HOT_R0 << w_ra;
    assign w_rb_oh = ONE_HOT_R0 << w_rb;
    assign w_rc_oh = ONE_HOT_R0 << w_rc;

    // The low IR bits carry no meaning for this instruction set.
    assign w_unused_ir = ^i_ir[RC_LO-1:0];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_is_alu  = 1'b1;
        w_unary   = 1'b0;
        w_alu_sel = 5'b00000;
        case (w_op)
            OP_ADD: w_alu_sel = 5'b00011;
            OP_SUB: w_alu_sel = 5'b00010;
            OP_AND: w_alu_sel = 5'b00100;
            OP_OR:  w_alu_sel = 5'b00101;
            OP_SHR: w_alu_sel = 5'b00110;
            OP_SHL: w_alu_sel = 5'b00111;
            OP_NEG: begin
                w_alu_sel = 5'b01000;
                w_unary   = 1'b1;
            end
            OP_NOT: begin
                w_alu_sel = 5'b01001;
                w_unary   = 1'b1;
            end
            default: w_is_alu = 1'b0;
        endcase
    end

    // Sequencing state. The first edge after reset release only arms the
    // unit, so T0 strobes appear one cycle after release.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_clr) begin
        if (!i_clr) begin
            r_state    <= S_T0;
            r_live     <= 1'b0;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_mem_err  <= 1'b0;
        end else if (!r_live) begin
            r_live <= 1'b1;
        end else begin
            case (r_state)
                S_T0: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_T1;
                end
                S_T1: begin
                    if (i_mem_ready) begin
                        r_state <= S_T2;
                    end else if (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        r_state   <= S_HALT;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    if (w_is_alu) begin
                        r_state <= S_T4;
                    end else if (w_op == OP_NOP) begin
                        r_state <= i_stop ? S_HALT : S_T0;
                    end else if (w_op == OP_HALT) begin
                        r_state <= S_HALT;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_T0;
                    end
                end
                S_T4: r_state <= S_T5;
                S_T5: r_state <= i_stop ? S_HALT : S_T0;
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Strobes are decoded from the present state rather than registered a
    // cycle ahead: IR loads on the same edge that enters T3, so the register
    // selects for T3 cannot be known any earlier. Every register feeding this
    // decode clears asynchronously, which drops all strobes as soon as clr falls.
    always_comb begin
        o_pcout      = 1'b0;
        o_zlowout    = 1'b0;
        o_mdrout     = 1'b0;
        o_pcin       = 1'b0;
        o_irin       = 1'b0;
        o_yin        = 1'b0;
        o_zin        = 1'b0;
        o_marin      = 1'b0;
        o_mdrin      = 1'b0;
        o_incpc      = 1'b0;
        o_read       = 1'b0;
        o_rin        = '0;
        o_rout       = '0;
        o_alu_select = 5'b00000;
        if (r_live) begin
            case (r_state)
                S_T0: begin
                    o_pcout = 1'b1;
                    o_marin = 1'b1;
                    o_incpc = 1'b1;
                    o_zin   = 1'b1;
                end
                S_T1: begin
                    o_zlowout = 1'b1;
                    o_pcin    = (r_wait_cnt == '0);  // one PC load per fetch
                    o_read    = 1'b1;
                    o_mdrin   = 1'b1;
                end
                S_T2: begin
                    o_mdrout = 1'b1;
                    o_irin   = 1'b1;
                end
                S_T3: begin
                    if (w_is_alu) begin
                        o_rout = w_rb_oh;
                        o_yin  = 1'b1;
                    end
                end
                S_T4: begin
                    o_rout       = w_unary ? w_rb_oh : w_rc_oh;
                    o_alu_select = w_alu_sel;
                    o_zin        = 1'b1;
                end
                S_T5: begin
                    o_zlowout = 1'b1;
                    o_rin     = w_ra_oh;
                end
                default: ;
            endcase
        end
    end

    assign o_run     = (r_state != S_HALT);
    assign o_illegal = r_illegal;
    assign o_mem_err = r_mem_err;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Self-checking bench for control_sequencer. A hand-written decode table
// checks the register selects and ALU codes. An instruction-level model then
// expands each instruction (opcode, memory delay, stop timing) into the
// strobe pattern expected on every cycle. That model drives randomized
// instruction streams and the multi-cycle corner cases: wait states, memory
// timeout, illegal and halt opcodes, stop requests and an asynchronous reset
// mid-instruction.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int NUM_REGS    = 16;
    localparam int MEM_TIMEOUT = 15;
    localparam int NEVER       = 1000;

    logic                i_clock = 1'b0;
    logic                i_clr   = 1'b0;
    logic [31:0]         i_ir    = '0;
    logic                i_mem_ready = 1'b0;
    logic                i_stop  = 1'b0;
    logic                o_pcout, o_zlowout, o_mdrout, o_pcin, o_irin, o_yin;
    logic                o_zin, o_marin, o_mdrin, o_incpc, o_read;
    logic [NUM_REGS-1:0] o_rin, o_rout;
    logic [4:0]          o_alu_select;
    logic                o_run, o_illegal, o_mem_err;

    control_sequencer #(
        .OP_W(5), .RSEL_W(4), .NUM_REGS(NUM_REGS), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .i_clock(i_clock), .i_clr(i_clr), .i_ir(i_ir),
        .i_mem_ready(i_mem_ready), .i_stop(i_stop),
        .o_pcout(o_pcout), .o_zlowout(o_zlowout), .o_mdrout(o_mdrout),
        .o_pcin(o_pcin), .o_irin(o_irin), .o_yin(o_yin), .o_zin(o_zin),
        .o_marin(o_marin), .o_mdrin(o_mdrin), .o_incpc(o_incpc),
        .o_read(o_read), .o_rin(o_rin), .o_rout(o_rout),
        .o_alu_select(o_alu_select), .o_run(o_run),
        .o_illegal(o_illegal), .o_mem_err(o_mem_err)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every observable output in one packed record.
    typedef struct packed {
        logic        pcout, zlowout, mdrout, pcin, irin, yin, zin, marin, mdrin, incpc, read;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        run, illegal, mem_err;
    } obs_t;

    // One planned cycle: inputs to drive and the outputs required in it.
    typedef struct {
        logic        rdy;
        logic        stp;
        logic [31:0] ir;
        obs_t        exp;
        int          ph;
    } step_t;

    // Decode table: hand-computed register selects and ALU codes.
    typedef struct {
        logic [31:0] ir;
        logic [15:0] t3_rout;
        logic [15:0] t4_rout;
        logic [4:0]  alu;
        logic [15:0] t5_rin;
    } vec_t;

    int    n_checks = 0;
    int    n_errors = 0;
    step_t plan[$];

    // Model state: sticky flags and whether the unit has stopped.
    logic m_illegal = 1'b0;
    logic m_mem_err = 1'b0;
    logic m_halted  = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.pcout   = o_pcout;   o.zlowout = o_zlowout; o.mdrout = o_mdrout;
        o.pcin    = o_pcin;    o.irin    = o_irin;    o.yin    = o_yin;
        o.zin     = o_zin;     o.marin   = o_marin;   o.mdrin  = o_mdrin;
        o.incpc   = o_incpc;   o.read    = o_read;
        o.rin     = o_rin;     o.rout    = o_rout;    o.alu    = o_alu_select;
        o.run     = o_run;     o.illegal = o_illegal; o.mem_err = o_mem_err;
        return o;
    endfunction

    // Opcode -> ALU_select, or -1 for anything that is not an ALU instruction.
    function automatic int alu_code(input logic [4:0] op);
        case (op)
            5'b00011: return 3;
            5'b00100: return 2;
            5'b01001: return 4;
            5'b01010: return 5;
            5'b00101: return 6;
            5'b00110: return 7;
            5'b10000: return 8;
            5'b10001: return 9;
            default:  return -1;
        endcase
    endfunction

    // An all-quiet cycle with the current status flags.
    function automatic obs_t base();
        obs_t o = '0;
        o.run     = !m_halted;
        o.illegal = m_illegal;
        o.mem_err = m_mem_err;
        return o;
    endfunction

    task automatic push(input logic [31:0] ir, input logic rdy, input logic stp,
                        input obs_t o, input int ph);
        step_t s;
        s.rdy = rdy; s.stp = stp; s.ir = ir; s.exp = o; s.ph = ph;
        plan.push_back(s);
    endtask

    // Expand one instruction into its cycle-by-cycle expectation. delay is the
    // number of T1 cycles before mem_ready; stop is held high from cycle
    // index stop_from (counted from T0) onward.
    task automatic plan_instr(input logic [31:0] ir, input int delay, input int stop_from);
        obs_t       o;
        int         k  = 0;
        logic [4:0] op = ir[31:27];
        int         ra = int'(ir[26:23]);
        int         rb = int'(ir[22:19]);
        int         rc = int'(ir[18:15]);
        int         alu = alu_code(op);

        o = base(); o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin = 1;
        push(ir, 1'b0, k >= stop_from, o, 0); k++;

        for (int w = 0; w <= delay && w < MEM_TIMEOUT; w++) begin
            o = base(); o.zlowout = 1; o.read = 1; o.mdrin = 1; o.pcin = (w == 0);
            push(ir, w == delay, k >= stop_from, o, 1); k++;
        end
        if (delay >= MEM_TIMEOUT) begin
            m_mem_err = 1'b1;
            m_halted  = 1'b1;
            return;
        end

        o = base(); o.mdrout = 1; o.irin = 1;
        push(ir, 1'b0, k >= stop_from, o, 2); k++;

        o = base();
        if (alu >= 0) begin
            o.rout = 16'(1) << rb; o.yin = 1;
            push(ir, 1'b0, k >= stop_from, o, 3); k++;
            o = base();
            o.rout = (op == 5'b10000 || op == 5'b10001) ? (16'(1) << rb) : (16'(1) << rc);
            o.alu  = 5'(alu); o.zin = 1;
            push(ir, 1'b0, k >= stop_from, o, 4); k++;
            o = base(); o.zlowout = 1; o.rin = 16'(1) << ra;
            push(ir, 1'b0, k >= stop_from, o, 5);
            if (k >= stop_from) m_halted = 1'b1;
        end else if (op == 5'b00000) begin
            push(ir, 1'b0, k >= stop_from, o, 3);
            if (k >= stop_from) m_halted = 1'b1;
        end else if (op == 5'b11011) begin
            push(ir, 1'b0, k >= stop_from, o, 3);
            m_halted = 1'b1;
        end else begin
            push(ir, 1'b0, k >= stop_from, o, 3);
            m_illegal = 1'b1;
        end
    endtask

    // Cycles with random inputs where nothing should change (used in HALT).
    task automatic plan_idle(input int n);
        for (int i = 0; i < n; i++)
            push($urandom, 1'($urandom), 1'($urandom), base(), 7);
    endtask

    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge i_clock);
            i_ir = s.ir; i_mem_ready = s.rdy; i_stop = s.stp;
            #1;
            check($sformatf("cycle ph%0d ir=%h", s.ph, s.ir), 64'(sample()), 64'(s.exp));
        end
    endtask

    // Reset is asserted between clock edges so the check right after it can
    // only pass if outputs clear asynchronously.
    task automatic do_reset();
        obs_t r;
        #2 i_clr = 1'b0; i_mem_ready = 1'b0; i_stop = 1'b0;
        m_illegal = 1'b0; m_mem_err = 1'b0; m_halted = 1'b0;
        r = base();
        #1 check("reset asserted", 64'(sample()), 64'(r));
        repeat (2) @(negedge i_clock);
        i_clr = 1'b1;
        #1 check("reset released", 64'(sample()), 64'(r));
    endtask

    task automatic drive(input logic [31:0] ir, input logic rdy);
        @(negedge i_clock);
        i_ir = ir; i_mem_ready = rdy; i_stop = 1'b0;
        #1;
    endtask

    vec_t       vecs [8];
    logic [4:0] alu_ops [8];
    logic [31:0] ir;
    logic [4:0]  op;

    initial begin
        vecs[0] = '{32'h4A920000, 16'h0004, 16'h0010, 5'b00100, 16'h0020}; // and R5,R2,R4
        vecs[1] = '{32'h18918000, 16'h0004, 16'h0008, 5'b00011, 16'h0002}; // add R1,R2,R3
        vecs[2] = '{32'h207B8000, 16'h8000, 16'h0080, 5'b00010, 16'h0001}; // sub R0,R15,R7
        vecs[3] = '{32'h57800000, 16'h0001, 16'h0001, 5'b00101, 16'h8000}; // or  R15,R0,R0
        vecs[4] = '{32'h29998000, 16'h0008, 16'h0008, 5'b00110, 16'h0008}; // shr R3,R3,R3
        vecs[5] = '{32'h33C48000, 16'h0100, 16'h0200, 5'b00111, 16'h0080}; // shl R7,R8,R9
        vecs[6] = '{32'h82350000, 16'h0040, 16'h0040, 5'b01000, 16'h0010}; // neg R4,R6,R10
        vecs[7] = '{32'h8C8E0000, 16'h0002, 16'h0002, 5'b01001, 16'h0200}; // not R9,R1,R12
        alu_ops = '{5'd3, 5'd4, 5'd9, 5'd10, 5'd5, 5'd6, 5'd16, 5'd17};

        do_reset();

        // Decode table, memory ready in the first T1 cycle: six cycles each,
        // the next instruction's T0 lands on cycle 7.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].ir, 1'b0);
            check($sformatf("tbl%0d T0 strobes", i),
                  64'({o_pcout, o_marin, o_incpc, o_zin, o_read}), 64'(5'b11110));
            drive(vecs[i].ir, 1'b1);
            check($sformatf("tbl%0d T1 strobes", i),
                  64'({o_zlowout, o_pcin, o_read, o_mdrin, o_pcout}), 64'(5'b11110));
            drive(vecs[i].ir, 1'b0);
            check($sformatf("tbl%0d T2 strobes", i), 64'({o_mdrout, o_irin, o_read}), 64'(3'b110));
            drive(vecs[i].ir, 1'b0);
            check($sformatf("tbl%0d T3 yin/rout", i), 64'({o_yin, o_rout}), 64'({1'b1, vecs[i].t3_rout}));
            drive(vecs[i].ir, 1'b0);
            check($sformatf("tbl%0d T4 zin/alu/rout", i),
                  64'({o_zin, o_alu_select, o_rout}), 64'({1'b1, vecs[i].alu, vecs[i].t4_rout}));
            drive(vecs[i].ir, 1'b0);
            check($sformatf("tbl%0d T5 zlow/rin/rout", i),
                  64'({o_zlowout, o_rin, o_rout}), 64'({1'b1, vecs[i].t5_rin, 16'h0000}));
        end

        // Randomized instruction stream: ALU ops, nops and undefined opcodes
        // with random wait states up to the last cycle before timeout.
        for (int n = 0; n < 150; n++) begin
            int kind = int'($urandom_range(0, 9));
            int dly  = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 4));
            ir = $urandom;
            if (kind == 0) begin
                op = 5'b00000;
            end else if (kind == 1) begin
                do op = 5'($urandom_range(0, 31));
                while (alu_code(op) >= 0 || op == 5'b00000 || op == 5'b11011);
            end else begin
                op = alu_ops[$urandom_range(0, 7)];
            end
            ir[31:27] = op;
            plan_instr(ir, dly, NEVER);
        end
        run_plan();

        // Memory ready after three wait cycles: Read/MDRin held four cycles, PCin once.
        do_reset();
        plan_instr(32'h4A920000, 3, NEVER);
        plan_instr(32'h18918000, 0, NEVER);
        run_plan();

        // Memory never answers: fifteen T1 cycles, then HALT with mem_err.
        do_reset();
        plan_instr(32'h18918000, 100, NEVER);
        plan_idle(4);
        run_plan();

        // Undefined opcode sets illegal without a register write; halt opcode stops after T3.
        do_reset();
        plan_instr(32'hF8000000 | 32'h00A98000, 0, NEVER);
        plan_instr(32'h4A920000, 1, NEVER);
        plan_instr(32'hD8000000, 0, NEVER);
        plan_idle(4);
        run_plan();

        // Stop raised in T1 of an ALU instruction: completes through T5, then HALT.
        do_reset();
        plan_instr(32'h207B8000, 2, 1);
        plan_idle(3);
        run_plan();

        // Stop sampled in T3 of a nop halts at that boundary.
        do_reset();
        plan_instr(32'h00001234, 0, NEVER);
        plan_instr(32'h00000000, 1, 0);
        plan_idle(3);
        run_plan();

        // Reset asserted during T4, then a clean restart from T0.
        do_reset();
        plan_instr(32'h4A920000, 0, NEVER);
        void'(plan.pop_back());
        run_plan();
        do_reset();
        plan_instr(32'h82350000, 1, NEVER);
        run_plan();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
